// File: rtl/tdm_demux_4x1_pkg.sv
// Shared constants, state encoding and lane-slice helper for the TDM demux.
package tdm_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Bit offset of a lane inside the assembled frame word.
  function automatic int lane_off(input int slot, input int width);
    return slot * width;
  endfunction

endpackage

// File: rtl/tdm_demux_4x1_if.sv
// TDM stream in / parallel frame out bundle.
interface tdm_demux_4x1_if
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0]           din;
  logic                       din_valid;
  logic                       frame_sync;
  logic [NUM_SLOTS*WIDTH-1:0] frame_data;
  logic                       frame_valid;
  logic                       locked;
  logic [SLOT_W-1:0]          slot;
  logic                       sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  frame_data, frame_valid, locked, slot, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output frame_data, frame_valid, locked, slot, sync_err
  );
endinterface

// File: rtl/tdm_demux_4x1_sync_fsm.sv
// Frame-lock FSM: tracks slot position, decides which lane a beat lands in,
// flags frame completion and framing violations.
module tdm_sync_fsm
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid_i,
  input  logic              frame_sync_i,
  output logic              capture_en_o,
  output logic [SLOT_W-1:0] capture_slot_o,
  output logic              frame_done_o,
  output logic              sync_err_o,
  output logic              locked_o,
  output logic [SLOT_W-1:0] slot_o
);

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              err_q, err_d;

  // State, slot counter and the registered error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      err_q   <= err_d;
    end
  end

  // Next state and per-beat capture decisions; idle cycles change nothing.
  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    err_d          = 1'b0;
    capture_en_o   = 1'b0;
    capture_slot_o = slot_q;
    frame_done_o   = 1'b0;
    if (din_valid_i) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync_i) begin
            capture_en_o   = 1'b1;
            capture_slot_o = '0;
            slot_d         = SLOT_W'(1);
            state_d        = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync_i && slot_q != '0) begin
            // Early sync: restart the frame on this beat.
            err_d          = 1'b1;
            capture_en_o   = 1'b1;
            capture_slot_o = '0;
            slot_d         = SLOT_W'(1);
          end else if (!frame_sync_i && slot_q == '0) begin
            // Missing sync: drop the beat and re-acquire.
            err_d   = 1'b1;
            slot_d  = '0;
            state_d = HUNT;
          end else begin
            capture_en_o = 1'b1;
            slot_d       = slot_q + SLOT_W'(1);
            frame_done_o = (slot_q == SLOT_W'(NUM_SLOTS - 1));
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign sync_err_o = err_q;
  assign locked_o   = (state_q == LOCKED);
  assign slot_o     = slot_q;

endmodule

// File: rtl/tdm_demux_4x1.sv
// 4-slot TDM demux: stages slots a..c, then publishes {d,c,b,a} on the slot-3 beat.
module tdm_demux_4x1
  import tdm_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int NUM_SLOTS_P = NUM_SLOTS
)(
  input  logic           clk,
  input  logic           rst,
  tdm_demux_4x1_if.slave bus
);

  logic                       capture_en;
  logic [SLOT_W-1:0]          capture_slot;
  logic                       frame_done;
  logic                       sync_err;
  logic                       locked;
  logic [SLOT_W-1:0]          slot;

  logic [NUM_SLOTS-2:0][WIDTH-1:0] stage_q, stage_d;
  logic [NUM_SLOTS*WIDTH-1:0]      frame_q, frame_d;
  logic                            fv_q;

  tdm_sync_fsm u_fsm (
    .clk            (clk),
    .rst            (rst),
    .din_valid_i    (bus.din_valid),
    .frame_sync_i   (bus.frame_sync),
    .capture_en_o   (capture_en),
    .capture_slot_o (capture_slot),
    .frame_done_o   (frame_done),
    .sync_err_o     (sync_err),
    .locked_o       (locked),
    .slot_o         (slot)
  );

  // Lanes a..c wait in staging; lane d goes straight into the frame word.
  always_comb begin
    stage_d = stage_q;
    frame_d = frame_q;
    for (int i = 0; i < NUM_SLOTS - 1; i++) begin
      if (capture_en && capture_slot == SLOT_W'(i))
        stage_d[i] = bus.din;
    end
    if (frame_done) begin
      for (int i = 0; i < NUM_SLOTS - 1; i++)
        frame_d[lane_off(i, WIDTH) +: WIDTH] = stage_q[i];
      frame_d[lane_off(NUM_SLOTS - 1, WIDTH) +: WIDTH] = bus.din;
    end
  end

  // Staging, frame word and the one-cycle frame_valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
      frame_q <= '0;
      fv_q    <= 1'b0;
    end else begin
      stage_q <= stage_d;
      frame_q <= frame_d;
      fv_q    <= frame_done;
    end
  end

  assign bus.frame_data  = frame_q;
  assign bus.frame_valid = fv_q;
  assign bus.locked      = locked;
  assign bus.slot        = slot;
  assign bus.sync_err    = sync_err;

  logic unused_ok;
  assign unused_ok = (NUM_SLOTS_P == NUM_SLOTS);

endmodule

// File: tb/tb_tdm_demux_4x1.sv
// Self-checking bench for tdm_demux_4x1 (WIDTH=1) with a frame scoreboard.
module tb_tdm_demux_4x1;
  import tdm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdm_demux_4x1_if #(.WIDTH(1)) bus ();

  tdm_demux_4x1 #(.WIDTH(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         pass_cnt = 0;
  int         chk_cnt  = 0;
  logic [3:0] exp_q[$];
  int         fv_cnt  = 0;
  int         err_cnt = 0;
  int         cyc     = 0;
  int         last_fv_cyc = 0;

  // Monitor: settles just after each rising edge, pops the scoreboard on frames.
  always @(posedge clk) begin
    logic [3:0] e;
    #1;
    cyc = cyc + 1;
    if (bus.sync_err) err_cnt = err_cnt + 1;
    if (bus.frame_valid) begin
      fv_cnt      = fv_cnt + 1;
      last_fv_cyc = cyc;
      chk_cnt     = chk_cnt + 1;
      if (exp_q.size() == 0) begin
        $display("FAIL frame_unexpected got=%b expected none", bus.frame_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.frame_data !== e)
          $display("FAIL frame_data got=%b expected=%b", bus.frame_data, e);
        else pass_cnt = pass_cnt + 1;
      end
      chk_cnt = chk_cnt + 1;
      if (bus.sync_err !== 1'b0)
        $display("FAIL fv_err_overlap got=%b expected=0", bus.sync_err);
      else pass_cnt = pass_cnt + 1;
    end
  end

  task automatic beat(input logic d, input logic s);
    bus.din = d; bus.din_valid = 1'b1; bus.frame_sync = s;
    @(negedge clk);
    bus.din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.din = 1'($urandom_range(0, 1));
      bus.frame_sync = 1'($urandom_range(0, 1));
      bus.din_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    chk_cnt++;
    if ({bus.frame_data, bus.frame_valid, bus.locked, bus.slot, bus.sync_err} !== 9'b0)
      $display("FAIL reset_outputs got=%b expected=0",
               {bus.frame_data, bus.frame_valid, bus.locked, bus.slot, bus.sync_err});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int f0 = fv_cnt;
    exp_q.push_back(4'b1010);
    beat(1'b0, 1'b1);
    chk_cnt++;
    if (bus.locked !== 1'b1 || bus.slot !== 2'd1)
      $display("FAIL basic_lock got=%b/%0d expected=1/1", bus.locked, bus.slot);
    else pass_cnt++;
    beat(1'b1, 1'b0); beat(1'b0, 1'b0); beat(1'b1, 1'b0);
    chk_cnt++;
    if (bus.frame_valid !== 1'b1 || bus.frame_data !== 4'b1010)
      $display("FAIL basic_frame got=%b/%b expected=1/1010", bus.frame_valid, bus.frame_data);
    else pass_cnt++;
    chk_cnt++;
    if (bus.locked !== 1'b1 || bus.slot !== 2'd0 || fv_cnt - f0 != 1)
      $display("FAIL basic_state got=%b/%0d/%0d expected=1/0/1", bus.locked, bus.slot, fv_cnt - f0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int c0 = last_fv_cyc;
    int e0 = err_cnt;
    exp_q.push_back(4'b0101);
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b1, 1'b0); beat(1'b0, 1'b0);
    chk_cnt++;
    if (last_fv_cyc - c0 != 4)
      $display("FAIL b2b_spacing got=%0d expected=4", last_fv_cyc - c0);
    else pass_cnt++;
    chk_cnt++;
    if (bus.frame_data !== 4'b0101 || err_cnt != e0)
      $display("FAIL b2b_frame got=%b/%0d expected=0101/0", bus.frame_data, err_cnt - e0);
    else pass_cnt++;
    idle(1);
    chk_cnt++;
    if (bus.frame_valid !== 1'b0 || bus.frame_data !== 4'b0101)
      $display("FAIL hold_frame got=%b/%b expected=0/0101", bus.frame_valid, bus.frame_data);
    else pass_cnt++;
  endtask

  task automatic test_gaps();
    int f0 = fv_cnt;
    logic [3:0] pat = 4'b1010;
    exp_q.push_back(4'b1010);
    for (int i = 0; i < 4; i++) begin
      beat(pat[i], i == 0);
      idle(2);
      chk_cnt++;
      if (bus.slot !== 2'(i + 1))
        $display("FAIL gap_slot got=%0d expected=%0d", bus.slot, 2'(i + 1));
      else pass_cnt++;
    end
    chk_cnt++;
    if (fv_cnt - f0 != 1 || bus.frame_data !== 4'b1010)
      $display("FAIL gap_frame got=%0d/%b expected=1/1010", fv_cnt - f0, bus.frame_data);
    else pass_cnt++;
  endtask

  task automatic test_early_sync();
    int f0 = fv_cnt;
    beat(1'b1, 1'b1); beat(1'b0, 1'b0);
    beat(1'b1, 1'b1);
    chk_cnt++;
    if (bus.sync_err !== 1'b1 || bus.frame_valid !== 1'b0 || bus.slot !== 2'd1 || bus.locked !== 1'b1)
      $display("FAIL early_err got=%b%b/%0d/%b expected=10/1/1",
               bus.sync_err, bus.frame_valid, bus.slot, bus.locked);
    else pass_cnt++;
    exp_q.push_back(4'b0011);
    beat(1'b1, 1'b0);
    chk_cnt++;
    if (bus.sync_err !== 1'b0)
      $display("FAIL early_pulse got=%b expected=0", bus.sync_err);
    else pass_cnt++;
    beat(1'b0, 1'b0); beat(1'b0, 1'b0);
    chk_cnt++;
    if (fv_cnt - f0 != 1 || bus.frame_data !== 4'b0011)
      $display("FAIL early_frame got=%0d/%b expected=1/0011", fv_cnt - f0, bus.frame_data);
    else pass_cnt++;
  endtask

  task automatic test_missing_sync();
    int e0 = err_cnt;
    int f0 = fv_cnt;
    beat(1'b1, 1'b0);
    chk_cnt++;
    if (bus.sync_err !== 1'b1 || bus.locked !== 1'b0 || bus.slot !== 2'd0)
      $display("FAIL miss_err got=%b/%b/%0d expected=1/0/0", bus.sync_err, bus.locked, bus.slot);
    else pass_cnt++;
    beat(1'b1, 1'b0); beat(1'b0, 1'b0);
    chk_cnt++;
    if (bus.locked !== 1'b0 || bus.slot !== 2'd0 || err_cnt - e0 != 1 || fv_cnt != f0)
      $display("FAIL miss_hunt got=%b/%0d/%0d/%0d expected=0/0/1/0",
               bus.locked, bus.slot, err_cnt - e0, fv_cnt - f0);
    else pass_cnt++;
    exp_q.push_back(4'b0111);
    beat(1'b1, 1'b1); beat(1'b1, 1'b0); beat(1'b1, 1'b0); beat(1'b0, 1'b0);
    chk_cnt++;
    if (fv_cnt - f0 != 1 || bus.locked !== 1'b1)
      $display("FAIL miss_relock got=%0d/%b expected=1/1", fv_cnt - f0, bus.locked);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int f0;
    beat(1'b1, 1'b1); beat(1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if ({bus.frame_data, bus.frame_valid, bus.locked, bus.slot, bus.sync_err} !== 9'b0)
      $display("FAIL async_reset got=%b expected=0",
               {bus.frame_data, bus.frame_valid, bus.locked, bus.slot, bus.sync_err});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    f0 = fv_cnt;
    exp_q.push_back(4'b1100);
    beat(1'b0, 1'b1); beat(1'b0, 1'b0); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    chk_cnt++;
    if (fv_cnt - f0 != 1 || bus.frame_data !== 4'b1100)
      $display("FAIL post_reset_frame got=%0d/%b expected=1/1100", fv_cnt - f0, bus.frame_data);
    else pass_cnt++;
  endtask

  initial begin
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.frame_sync = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_gaps();
    test_early_sync();
    test_missing_sync();
    test_async_reset();
    idle(3);
    chk_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/tdm_demux_4x1.md
Name: tdm_demux_4x1

Overview:
- Receive-side counterpart of the team's 4:1 channel mux. Takes a time-division-multiplexed stream of four slots (a, b, c, d order) and reassembles each frame into four parallel lanes.
- Locks to a frame_sync marker on slot 0 and tracks slot position with a 2-bit counter. Emits one registered frame per four accepted beats.
- Sits downstream of the serialiser and upstream of per-channel consumers.

Parameters:
- WIDTH, 1, bits per slot (per channel sample).
- NUM_SLOTS, 4, slots per frame; fixed at 4, present for package consistency only.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  slot sample.
- din_valid  input  1  beat qualifier; din and frame_sync are ignored when low.
- frame_sync  input  1  marks the current valid beat as slot 0 (channel a).
- frame_data  output  4*WIDTH  assembled frame: [WIDTH-1:0]=a, next=b, next=c, MSBs=d.
- frame_valid  output  1  one-cycle pulse; frame_data is new this cycle.
- locked  output  1  high while the FSM is in LOCKED.
- slot  output  2  slot index expected on the next valid beat.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (async assert, released synchronously by the clock): frame_data=0, frame_valid=0, locked=0, slot=0, sync_err=0, staging lanes 0, state=HUNT. Reset asserted mid-frame discards the partial frame immediately.
- States: HUNT, LOCKED. Encoding is defined in the package.
- HUNT:
  - Valid beats without frame_sync are dropped; slot stays 0.
  - Valid beat with frame_sync: capture din to stage0, slot<=1, go to LOCKED.
- LOCKED, on each valid beat:
  - Normal (frame_sync==(slot==0)): capture din into lane[slot], then slot<=slot+1 mod 4.
  - slot==3 beat: frame_data<={din,stage2,stage1,stage0}, frame_valid=1 in the following cycle (latency 1 clk from the slot-3 beat edge), slot wraps to 0.
  - Early sync (frame_sync=1, slot!=0): sync_err pulse; partial frame discarded with no frame_valid; din captured as slot 0; slot<=1; stay LOCKED.
  - Missing sync (frame_sync=0, slot==0): sync_err pulse; beat dropped; go to HUNT; locked falls the next cycle.
- din_valid low: no state change. frame_valid and sync_err are pulses only, never held.
- frame_data holds its last frame until the next complete frame or reset. Staging lanes are not visible on outputs.
- frame_valid and sync_err never assert in the same cycle.
- Back-to-back frames (a valid beat every cycle) give a frame_valid every 4th cycle with no bubbles.

Decomposition:
- Shared package tdm_pkg holds:
  - NUM_SLOTS=4 and SLOT_W=2.
  - State enum {HUNT, LOCKED}.
  - Lane-slice helper constants (offset=slot*WIDTH).
- One sub-module, tdm_sync_fsm:
  - Owns state and the slot counter.
  - Outputs capture_en, capture_slot, frame_done, sync_err.
- The top level keeps the staging and frame_data registers.

Test Plan:
- WIDTH=1, reset, beats sync+0,1,0,1 on consecutive cycles -> one cycle after the 4th beat frame_valid=1, frame_data=4'b1010, locked=1, slot=0.
- Continue with a second frame 1,0,1,0 back-to-back -> frame_valid 4 cycles after the first, frame_data=4'b0101, sync_err never asserted.
- Same frame with din_valid=0 gaps of 2 cycles between beats -> identical frame_data=4'b1010, a single frame_valid pulse, slot holds during gaps.
- LOCKED, beats a,b then frame_sync on the 3rd beat -> sync_err pulse, no frame_valid; the next 3 beats complete a new frame starting at that beat.
- LOCKED at slot 0, valid beat with frame_sync=0 -> sync_err pulse, locked=0 next cycle, following non-sync beats ignored until sync.
- Assert rst after 2 beats of a frame -> all outputs 0 asynchronously, before the next clk edge. After release, a full synced frame produces a correct frame_data with no stale lanes.
